// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a word-wide synchronous memory.
// Big-endian lanes; sub-word stores go through read-modify-write.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_WAIT, ST_WORD,
    RMW_ISSUE, RMW_WAIT, RMW_WRITE
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t      state, state_n;
  logic [1:0]  r_size, r_size_n;
  logic        r_uns, r_uns_n;
  logic [1:0]  r_off, r_off_n;
  logic [15:0] r_wd, r_wd_n;
  logic [4:0]  r_rd, r_rd_n;

  logic        mem_read_n, mem_write_n;
  logic [31:0] mem_addr_n, mem_din_n;
  logic        wb_valid_n, err_n;
  logic [4:0]  wb_rd_n;
  logic [31:0] wb_data_n;

  logic        mis;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_ext, merged;

  assign req_ready = (state == IDLE);

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      req_size == SZ_H: mis = req_addr[0];
      req_size == SZ_W: mis = |req_addr[1:0];
      req_size == SZ_B: mis = 1'b0;
      default:          mis = 1'b1;
    endcase
  end

  // Lane select: offset 0 is the most significant byte
  always_comb begin
    lb = 8'h00;
    case (r_off)
      2'd0:    lb = mem_dout[31:24];
      2'd1:    lb = mem_dout[23:16];
      2'd2:    lb = mem_dout[15:8];
      default: lb = mem_dout[7:0];
    endcase
    lh = r_off[1] ? mem_dout[15:0] : mem_dout[31:16];
    ld_ext = mem_dout;
    merged = mem_dout;
    if (r_size == SZ_B) begin
      ld_ext = {{24{lb[7] & ~r_uns}}, lb};
      case (r_off)
        2'd0:    merged = {r_wd[7:0], mem_dout[23:0]};
        2'd1:    merged = {mem_dout[31:24], r_wd[7:0],
                           mem_dout[15:0]};
        2'd2:    merged = {mem_dout[31:16], r_wd[7:0],
                           mem_dout[7:0]};
        default: merged = {mem_dout[31:8], r_wd[7:0]};
      endcase
    end else if (r_size == SZ_H) begin
      ld_ext = {{16{lh[15] & ~r_uns}}, lh};
      merged = r_off[1] ? {mem_dout[31:16], r_wd}
                        : {r_wd, mem_dout[15:0]};
    end
  end

  always_comb begin
    state_n     = state;
    r_size_n    = r_size;
    r_uns_n     = r_uns;
    r_off_n     = r_off;
    r_wd_n      = r_wd;
    r_rd_n      = r_rd;
    mem_read_n  = 1'b0;
    mem_write_n = 1'b0;
    mem_addr_n  = mem_addr;
    mem_din_n   = mem_din;
    wb_valid_n  = 1'b0;
    wb_rd_n     = wb_rd;
    wb_data_n   = wb_data;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (mis) begin
            err_n = 1'b1;
          end else begin
            r_size_n   = req_size;
            r_uns_n    = req_unsigned;
            r_off_n    = req_addr[1:0];
            r_wd_n     = req_wdata[15:0];
            r_rd_n     = req_rd;
            mem_addr_n = {req_addr[31:2], 2'b00};
            if (!req_write) begin
              state_n    = LD_ISSUE;
              mem_read_n = 1'b1;
            end else if (req_size == SZ_W) begin
              state_n     = ST_WORD;
              mem_write_n = 1'b1;
              mem_din_n   = req_wdata;
            end else begin
              state_n    = RMW_ISSUE;
              mem_read_n = 1'b1;
            end
          end
        end
      end
      LD_ISSUE:  state_n = LD_WAIT;
      LD_WAIT: begin
        state_n    = IDLE;
        wb_valid_n = 1'b1;
        wb_rd_n    = r_rd;
        wb_data_n  = ld_ext;
      end
      ST_WORD:   state_n = IDLE;
      RMW_ISSUE: state_n = RMW_WAIT;
      RMW_WAIT: begin
        state_n     = RMW_WRITE;
        mem_write_n = 1'b1;
        mem_din_n   = merged;
      end
      RMW_WRITE: state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_off        <= 2'b00;
      r_wd         <= 16'h0;
      r_rd         <= 5'd0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= 32'h0;
      mem_din      <= 32'h0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      r_size       <= r_size_n;
      r_uns        <= r_uns_n;
      r_off        <= r_off_n;
      r_wd         <= r_wd_n;
      r_rd         <= r_rd_n;
      mem_read     <= mem_read_n;
      mem_write    <= mem_write_n;
      mem_addr     <= mem_addr_n;
      mem_din      <= mem_din_n;
      wb_valid     <= wb_valid_n;
      wb_rd        <= wb_rd_n;
      wb_data      <= wb_data_n;
      misalign_err <= err_n;
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: none; widths fixed (32-bit data/address, 5-bit register index).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  EX/MEM request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 req_rd  input  5  load destination register.
REQ-012 mem_read / mem_write  output  1 each  commands to the word memory (mem32).
REQ-013 mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-014 mem_din  output  32  word written to memory.
REQ-015 mem_dout  input  32  memory read data.
REQ-016 wb_valid  output  1  one-cycle pulse, load result valid.
REQ-017 wb_rd  output  5  / wb_data  output  32  load destination and extended result.
REQ-018 misalign_err  output  1  one-cycle pulse, request rejected.

Function
REQ-019 Memory contract: the memory samples mem_read/mem_write/mem_addr/mem_din on a rising edge. mem_dout is valid during the cycle after that edge.
REQ-020 All outputs except req_ready SHALL be registered. req_ready SHALL be 1 exactly when state is IDLE.
REQ-021 States: IDLE, LD_ISSUE, LD_WAIT, ST_WORD, RMW_ISSUE, RMW_WAIT, RMW_WRITE.
REQ-022 Accept = req_valid && req_ready at an edge. With no accept, IDLE holds and mem_read = mem_write = 0.
REQ-023 Misaligned accept (half with addr[0]=1, word with addr[1:0]!=0, or size 11) SHALL:
- pulse misalign_err for the next cycle;
- issue no memory command and no wb_valid;
- remain in IDLE.
REQ-024 Load path:
- Accept -> LD_ISSUE, with mem_read=1 and mem_addr set for that cycle.
- Next edge -> LD_WAIT, mem_read=0.
- Next edge: capture extracted mem_dout into wb_data, pulse wb_valid with wb_rd, return to IDLE.
- wb_valid is therefore high in the third cycle after the accept edge.
REQ-025 Byte lanes are big-endian:
- offset 0 = bits[31:24], offset 3 = bits[7:0];
- halfword offset 0 = [31:16], offset 2 = [15:0].
REQ-026 Extension to 32 bits SHALL follow req_unsigned. Word loads are passed unchanged.
REQ-027 Word store: accept -> ST_WORD, with mem_write=1 and mem_din=req_wdata for one cycle. Next edge -> IDLE.
REQ-028 Byte/halfword store (read-modify-write):
- Accept -> RMW_ISSUE (mem_read=1).
- Next edge -> RMW_WAIT.
- Next edge: merge the low byte/half of req_wdata into the addressed lane of mem_dout, drive mem_write=1, enter RMW_WRITE.
- Next edge -> IDLE.
- Unaddressed lanes SHALL be preserved bit-exact.
REQ-029 Request fields (write, size, unsigned, addr, wdata, rd) SHALL be latched at accept and used until return to IDLE. req_* changes while busy SHALL be ignored.
REQ-030 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-031 Stores SHALL never assert wb_valid.
REQ-032 wb_data/wb_rd SHALL hold their last value when wb_valid=0.

Reset
REQ-033 While rst_n=0, immediately and regardless of clock:
- state=IDLE;
- mem_read = mem_write = 0;
- mem_addr = mem_din = 0;
- wb_valid = misalign_err = 0;
- wb_data = 0, wb_rd = 0.
REQ-034 Reset mid-operation SHALL abandon the access:
- no write is issued for an interrupted RMW;
- no wb_valid is produced for an interrupted load.
REQ-035 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-036 Word store then load: store 0xDEADBEEF at 0x40, then load word at 0x40 -> mem_write seen 1 cycle with mem_addr 0x40; wb_data=0xDEADBEEF pulsed 3rd cycle after accept.
REQ-037 Signed/unsigned byte: memory word 0x12F45678 at 0x40, lb at 0x41 -> wb_data 0xFFFFFFF4; lbu at 0x41 -> 0x000000F4; lh at 0x42 -> 0x00005678.
REQ-038 Sub-word store: memory 0x11223344 at 0x40, sb 0xAB at 0x42 -> mem_din 0x1122AB44, and exactly one read then one write with req_ready=0 throughout. sh 0xCAFE at 0x40 -> 0xCAFE3344.
REQ-039 Misalignment: lw at 0x42, lh at 0x41, size 11 -> misalign_err pulse each, no mem_read/mem_write, req_ready stays 1.
REQ-040 Reset mid-RMW: assert rst_n=0 during RMW_WAIT -> mem_read/mem_write 0 immediately, memory word unchanged, req_ready=1 after release.
REQ-041 Back-to-back: req_valid held high with changing fields -> only requests sampled in IDLE are performed, in order, none lost or duplicated.
